// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - per-port request/response channel of the shared ALU arbiter
// The requester drives the request side and consumes the response side.
interface alu_share_arbiter_if #(parameter int W = 8);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [1:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W:0]   rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one registered add/sub/pass unit between two ports
// Each port owns a one-entry result register; a full, stalled register makes its port ineligible.
module alu_share_arbiter #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   port0,
    alu_share_arbiter_if.slave   port1,
    output logic [CW-1:0]        gnt_cnt0,
    output logic [CW-1:0]        gnt_cnt1
);

    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [W:0]    rsp0_data_q,  rsp0_data_d;
    logic [W:0]    rsp1_data_q,  rsp1_data_d;
    logic [CW-1:0] gnt_cnt0_q,   gnt_cnt0_d;
    logic [CW-1:0] gnt_cnt1_q,   gnt_cnt1_d;
    logic          last_grant_q, last_grant_d;

    logic elig0, elig1, grant0, grant1;

    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
        logic [W:0] ax;
        logic [W:0] bx;
        logic [W:0] r;
        ax = {a[W-1], a};
        bx = {b[W-1], b};
        case (op)
            2'b00:   r = ax;
            2'b01:   r = bx;
            2'b10:   r = ax + bx;
            default: r = ax - bx;
        endcase
        return r;
    endfunction

    // A slot that is draining this cycle can be refilled in the same cycle.
    assign elig0  = port0.req_valid && (!rsp0_valid_q || port0.rsp_ready);
    assign elig1  = port1.req_valid && (!rsp1_valid_q || port1.rsp_ready);
    assign grant0 = elig0 && (!elig1 || last_grant_q);
    assign grant1 = elig1 && (!elig0 || !last_grant_q);

    assign port0.req_ready = grant0;
    assign port1.req_ready = grant1;
    assign port0.rsp_valid = rsp0_valid_q;
    assign port1.rsp_valid = rsp1_valid_q;
    assign port0.rsp_data  = rsp0_data_q;
    assign port1.rsp_data  = rsp1_data_q;
    assign gnt_cnt0        = gnt_cnt0_q;
    assign gnt_cnt1        = gnt_cnt1_q;

    always_comb begin
        rsp0_valid_d = rsp0_valid_q && !port0.rsp_ready;
        rsp1_valid_d = rsp1_valid_q && !port1.rsp_ready;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        gnt_cnt0_d   = gnt_cnt0_q;
        gnt_cnt1_d   = gnt_cnt1_q;
        last_grant_d = last_grant_q;
        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_f(port0.req_a, port0.req_b, port0.req_op);
            last_grant_d = 1'b0;
            if (gnt_cnt0_q != {CW{1'b1}})
                gnt_cnt0_d = gnt_cnt0_q + CW'(1);
        end
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_f(port1.req_a, port1.req_b, port1.req_op);
            last_grant_d = 1'b1;
            if (gnt_cnt1_q != {CW{1'b1}})
                gnt_cnt1_d = gnt_cnt1_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            gnt_cnt0_q   <= '0;
            gnt_cnt1_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            gnt_cnt0_q   <= gnt_cnt0_d;
            gnt_cnt1_q   <= gnt_cnt1_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] gnt_cnt0, gnt_cnt1;
    logic [3:0]  sat_cnt0, sat_cnt1;

    int n_checks;
    int n_errors;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         lat0, lat1;

    alu_share_arbiter_if #(.W(8)) p0();
    alu_share_arbiter_if #(.W(8)) p1();
    alu_share_arbiter_if #(.W(8)) s0();
    alu_share_arbiter_if #(.W(8)) s1();

    alu_share_arbiter #(.W(8), .CW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .port0    (p0),
        .port1    (p1),
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
    );

    alu_share_arbiter #(.W(8), .CW(4)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .port0    (s0),
        .port1    (s1),
        .gnt_cnt0 (sat_cnt0),
        .gnt_cnt1 (sat_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] alu_model(input logic signed [7:0] a, input logic signed [7:0] b,
                                             input logic [1:0] op);
        int ai;
        int bi;
        int r;
        ai = a;
        bi = b;
        case (op)
            2'd0:    r = ai;
            2'd1:    r = bi;
            2'd2:    r = ai + bi;
            default: r = ai - bi;
        endcase
        return 9'(r);
    endfunction

    // Scoreboard: push on every accepted request, pop on every consumed result.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            lat0 = 1'b0;
            lat1 = 1'b0;
        end else begin
            check_val("rdy_onehot", 32'(p0.req_ready & p1.req_ready), 0);
            check_val("rdy0_without_valid", 32'(p0.req_ready & ~p0.req_valid), 0);
            check_val("rdy1_without_valid", 32'(p1.req_ready & ~p1.req_valid), 0);
            if (lat0) check_val("rsp0_latency", 32'(p0.rsp_valid), 1);
            if (lat1) check_val("rsp1_latency", 32'(p1.rsp_valid), 1);
            if (p0.rsp_valid && p0.rsp_ready) begin
                check_val("rsp0_expected", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) check_val("rsp0_data", 32'(p0.rsp_data), 32'(q0.pop_front()));
            end
            if (p1.rsp_valid && p1.rsp_ready) begin
                check_val("rsp1_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) check_val("rsp1_data", 32'(p1.rsp_data), 32'(q1.pop_front()));
            end
            lat0 = p0.req_valid && p0.req_ready;
            lat1 = p1.req_valid && p1.req_ready;
            if (lat0) q0.push_back(alu_model(p0.req_a, p0.req_b, p0.req_op));
            if (lat1) q1.push_back(alu_model(p1.req_a, p1.req_b, p1.req_op));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input bit v, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
        if (port == 0) begin
            p0.req_valid = v; p0.req_a = a; p0.req_b = b; p0.req_op = op;
        end else begin
            p1.req_valid = v; p1.req_a = a; p1.req_b = b; p1.req_op = op;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        p0.rsp_ready = 1'b1;
        p1.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [1:0] t2_op  [4] = '{2'd3, 2'd3, 2'd0, 2'd1};
    logic [7:0] t2_a   [4] = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    logic [7:0] t2_b   [4] = '{8'h7F, 8'h80, 8'h00, 8'h05};
    logic [8:0] t2_exp [4] = '{9'h101, 9'h0FF, 9'h1FF, 9'h005};

    initial begin
        n_checks = 0;
        n_errors = 0;
        s0.req_valid = 0; s0.req_a = 0; s0.req_b = 0; s0.req_op = 0; s0.rsp_ready = 1;
        s1.req_valid = 0; s1.req_a = 0; s1.req_b = 0; s1.req_op = 0; s1.rsp_ready = 1;

        // Reset values and a first add on port 0
        do_reset();
        check_val("rst_rsp0_valid", 32'(p0.rsp_valid), 0);
        check_val("rst_rsp1_valid", 32'(p1.rsp_valid), 0);
        check_val("rst_rsp0_data", 32'(p0.rsp_data), 0);
        check_val("rst_rsp1_data", 32'(p1.rsp_data), 0);
        check_val("rst_gnt_cnt0", 32'(gnt_cnt0), 0);
        check_val("rst_gnt_cnt1", 32'(gnt_cnt1), 0);
        drive(0, 1, 8'd100, 8'd100, 2'd2);
        @(negedge clk);
        check_val("t1_req0_ready", 32'(p0.req_ready), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        check_val("t1_rsp0_valid", 32'(p0.rsp_valid), 1);
        check_val("t1_rsp0_data", 32'(p0.rsp_data), 32'h0C8);
        check_val("t1_gnt_cnt0", 32'(gnt_cnt0), 1);

        // Operand extremes and pass ops on port 1
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, t2_a[i], t2_b[i], t2_op[i]);
            next_cycle();
            check_val("t2_rsp1_valid", 32'(p1.rsp_valid), 1);
            check_val("t2_rsp1_data", 32'(p1.rsp_data), 32'(t2_exp[i]));
        end
        drive(1, 0, 0, 0, 0);
        next_cycle();

        // Continuous contention alternates starting with port 0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 8'($urandom), 8'($urandom), 2'($urandom));
            drive(1, 1, 8'($urandom), 8'($urandom), 2'($urandom));
            @(negedge clk);
            check_val("t3_req0_ready", 32'(p0.req_ready), 32'(i % 2 == 0));
            check_val("t3_req1_ready", 32'(p1.req_ready), 32'(i % 2 == 1));
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check_val("t3_gnt_cnt0", 32'(gnt_cnt0), 3);
        check_val("t3_gnt_cnt1", 32'(gnt_cnt1), 3);
        next_cycle();

        // Backpressure on port 0 lets port 1 run every cycle
        do_reset();
        drive(0, 1, 8'd10, 8'd20, 2'd2);
        drive(1, 1, 8'($urandom), 8'($urandom), 2'($urandom));
        @(negedge clk);
        check_val("t4_first_req0_ready", 32'(p0.req_ready), 1);
        next_cycle();
        p0.rsp_ready = 1'b0;
        drive(0, 1, 8'hCE, 8'd7, 2'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t4_blocked_req0_ready", 32'(p0.req_ready), 0);
            check_val("t4_blocked_req1_ready", 32'(p1.req_ready), 1);
            next_cycle();
            drive(1, 1, 8'($urandom), 8'($urandom), 2'($urandom));
        end
        check_val("t4_hold_valid", 32'(p0.rsp_valid), 1);
        check_val("t4_hold_data", 32'(p0.rsp_data), 32'd30);
        p0.rsp_ready = 1'b1;
        @(negedge clk);
        check_val("t4_drain_req0_ready", 32'(p0.req_ready), 1);
        check_val("t4_drain_req1_ready", 32'(p1.req_ready), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check_val("t4_second_valid", 32'(p0.rsp_valid), 1);
        check_val("t4_second_data", 32'(p0.rsp_data), 32'h1C7);
        next_cycle();

        // Reset with a pending, stalled port 1 result
        do_reset();
        p1.rsp_ready = 1'b0;
        drive(1, 1, 8'd3, 8'd4, 2'd2);
        next_cycle();
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 8'd1, 8'd1, 2'd2);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        check_val("t5_rsp1_valid", 32'(p1.rsp_valid), 0);
        check_val("t5_rsp0_valid", 32'(p0.rsp_valid), 0);
        check_val("t5_gnt_cnt0", 32'(gnt_cnt0), 0);
        check_val("t5_gnt_cnt1", 32'(gnt_cnt1), 0);
        p1.rsp_ready = 1'b1;
        drive(0, 1, 8'd9, 8'd2, 2'd3);
        drive(1, 1, 8'd9, 8'd2, 2'd2);
        @(negedge clk);
        check_val("t5_contention_req0", 32'(p0.req_ready), 1);
        check_val("t5_contention_req1", 32'(p1.req_ready), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        next_cycle();

        // Saturation of a 4-bit grant counter
        do_reset();
        for (int i = 0; i < 20; i++) begin
            s0.req_valid = 1'b1;
            s0.req_a = 8'(i);
            s0.req_op = 2'd0;
            next_cycle();
            check_val("t6_sat_cnt0", 32'(sat_cnt0), (i + 1 > 15) ? 15 : i + 1);
        end
        s0.req_valid = 1'b0;
        check_val("t6_sat_cnt1", 32'(sat_cnt1), 0);
        check_val("t6_sat_rsp0_data", 32'(s0.rsp_data), 32'd19);

        repeat (3) next_cycle();
        check_val("end_q0_empty", 32'(q0.size()), 0);
        check_val("end_q1_empty", 32'(q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one signed add/sub/pass unit between two requesters, port 0 and port 1.
- Each port sends an operand pair and an opcode over a valid/ready handshake.
- A round-robin arbiter grants at most one request per cycle.
- The result returns on that port's own response channel. Each response channel has a one-entry holding register and valid/ready backpressure.
- Sits between the two requesting engines and the shared arithmetic unit. The ALU is instantiated inside this block as a registered stage.

Parameters:
W, 8, operand width; results are W+1 bits, signed, two's complement.
CW, 16, width of the per-port saturating grant counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_a  in  W  port 0 operand a, signed
req0_b  in  W  port 0 operand b, signed
req0_op  in  2  port 0 opcode: 00 pass a, 01 pass b, 10 a+b, 11 a-b
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as port 0, for port 1
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 consumer takes result
rsp0_data  out  W+1  port 0 result, signed
rsp1_valid / rsp1_ready / rsp1_data  same as port 0, for port 1
gnt_cnt0  out  CW  saturating count of port 0 grants
gnt_cnt1  out  CW  saturating count of port 1 grants

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst; it is sampled only on the rising edge of clk.
- Reset values: rsp0_valid=0, rsp1_valid=0, rsp0_data=0, rsp1_data=0, gnt_cnt0=0, gnt_cnt1=0, last_grant=1 (port 0 wins the first contention).
- Reset mid-operation: a pending result is discarded, and no response is produced for a request accepted in the reset cycle.
- Slot eligibility: port N's slot is free when !rspN_valid || rspN_ready. Drain and refill can happen in the same cycle, giving one result per cycle per port.
- A port is eligible when reqN_valid=1 and its slot is free.
- Arbitration is combinational on the current cycle's inputs:
  - Only one port eligible: that port is granted.
  - Both eligible: grant the port != last_grant.
  - Neither eligible: no grant.
- reqN_ready=1 only for the granted port; at most one of req0_ready/req1_ready is high. A transfer occurs when reqN_valid && reqN_ready.
- reqN_ready may be high only while reqN_valid is high.
- On a transfer on port N, at the clock edge:
  - rspN_data <= f(a,b,op), rspN_valid <= 1.
  - last_grant <= N.
  - gnt_cntN increments, saturating at 2^CW-1 with no wrap.
- Latency: the result is visible on rspN_* exactly one cycle after the accepting edge.
- No transfer on port N: rspN_valid <= rspN_valid && !rspN_ready; rspN_data holds.
- Arithmetic: both operands are sign-extended to W+1 bits before the operation, so the result never overflows. Ranges: a+b in [-2^W, 2^W-2]; a-b in [-2^W+1, 2^W-1]. Pass ops are sign-extended.
- Backpressure: when rspN_valid=1 and rspN_ready=0, port N is ineligible.
  - The other port may then be granted every cycle; round-robin does not wait for a blocked port.
  - The blocked port keeps its priority relationship through last_grant.
- A requester may change its operands while not accepted; only values present at the transfer edge are used.
- No combinational path from reqN_* to rspN_*. Combinational paths exist from reqN_valid and rspN_ready to reqN_ready.

Test Plan:
1. Reset, then req0 op=10, a=100, b=100, rsp0_ready=1 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_data=9'sd200 (0x0C8); gnt_cnt0=1.
2. req1 op=11, a=-128, b=127 -> rsp1_data=-255 (0x101). Then op=11, a=127, b=-128 -> 255 (0x0FF). Then op=00, a=-1 -> 0x1FF. Then op=01, b=5 -> 0x005.
3. Both valid continuously, both rsp_ready=1, for 6 cycles -> grants 0,1,0,1,0,1; one result per cycle alternating ports; gnt_cnt0=gnt_cnt1=3.
4. Both valid, rsp0_ready=0 after port 0's first result -> req0_ready stays 0 and port 1 is granted every cycle. Raise rsp0_ready -> port 0 is granted the same cycle its slot drains; rsp0_data matches the second request.
5. Reset asserted in the cycle after a port 1 acceptance, result pending with rsp1_ready=0 -> after reset, rsp1_valid=0, counters 0, and the next contention is won by port 0.
6. CW=4 build, 20 grants to port 0 -> gnt_cnt0 holds 15 with no wrap; gnt_cnt1 unaffected.
